// File: rtl/de10lite_qsys_sw_irq_ctrl.sv
// Switch input controller with per-bit debounce, edge capture and level interrupt,
// exposed as a 4-word Avalon-MM slave.
//
// Ports:
//   clk         single clock, all state updates on its rising edge
//   reset       synchronous, active-high reset
//   address     register word address (0 deb, 1 irqmask, 2 edgecap, 3 period)
//   chipselect  slave select
//   write_n     active-low write strobe, qualified by chipselect
//   writedata   write data
//   readdata    registered read data, 1-cycle latency
//   in_port     raw asynchronous switch levels
//   irq         level interrupt, registered |(edgecap & irqmask)
module de10lite_qsys_sw_irq_ctrl #(
  parameter int unsigned DW          = 10,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned DEB_DEFAULT = 50000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    address,
  input  logic          chipselect,
  input  logic          write_n,
  input  logic [31:0]   writedata,
  output logic [31:0]   readdata,
  input  logic [DW-1:0] in_port,
  output logic          irq
);

  localparam logic [CNT_W-1:0] PeriodRst = CNT_W'(DEB_DEFAULT);
  localparam logic [CNT_W-1:0] CntMax    = '1;

  logic [DW-1:0]    sync1_q, sync2_q;
  logic [DW-1:0]    deb_q, deb_d;
  logic [DW-1:0]    edge_set;
  logic [DW-1:0]    irqmask_q, irqmask_d;
  logic [DW-1:0]    edgecap_q, edgecap_d;
  logic [DW-1:0]    ec_clr;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] cnt_q [DW];
  logic [CNT_W-1:0] cnt_d [DW];
  logic [31:0]      readdata_q, rd_mux;
  logic             irq_q, irq_d;
  logic             wr_en;
  logic             unused_wdata;

  assign wr_en        = chipselect & ~write_n;
  // Upper writedata bits are deliberately ignored for the narrower fields.
  assign unused_wdata = ^writedata;

  // Per-bit debounce: the counter measures how long sync2 has disagreed with deb.
  always_comb begin
    deb_d    = deb_q;
    edge_set = '0;
    for (int i = 0; i < int'(DW); i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync2_q[i] == deb_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] >= period_q) begin
        deb_d[i]    = sync2_q[i];
        edge_set[i] = 1'b1;
        cnt_d[i]    = '0;
      end else if (cnt_q[i] != CntMax) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // Register writes; a capture set on the same edge as a W1C wins.
  always_comb begin
    irqmask_d = irqmask_q;
    period_d  = period_q;
    ec_clr    = '0;
    if (wr_en) begin
      case (address)
        2'd1:    irqmask_d = writedata[DW-1:0];
        2'd2:    ec_clr    = writedata[DW-1:0];
        2'd3:    period_d  = writedata[CNT_W-1:0];
        default: ;
      endcase
    end
    edgecap_d = (edgecap_q & ~ec_clr) | edge_set;
    irq_d     = |(edgecap_q & irqmask_q);
  end

  // Read mux sees pre-write register values, so a same-cycle read returns old data.
  always_comb begin
    rd_mux = '0;
    case (address)
      2'd0:    rd_mux[DW-1:0]    = deb_q;
      2'd1:    rd_mux[DW-1:0]    = irqmask_q;
      2'd2:    rd_mux[DW-1:0]    = edgecap_q;
      default: rd_mux[CNT_W-1:0] = period_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      irqmask_q  <= '0;
      edgecap_q  <= '0;
      period_q   <= PeriodRst;
      readdata_q <= '0;
      irq_q      <= 1'b0;
      for (int i = 0; i < int'(DW); i++) cnt_q[i] <= '0;
    end else begin
      sync1_q    <= in_port;
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      irqmask_q  <= irqmask_d;
      edgecap_q  <= edgecap_d;
      period_q   <= period_d;
      readdata_q <= rd_mux;
      irq_q      <= irq_d;
      for (int i = 0; i < int'(DW); i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_de10lite_qsys_sw_irq_ctrl.sv
// Self-checking bench for de10lite_qsys_sw_irq_ctrl (DW=10, CNT_W=16, default period 50000).
module tb_de10lite_qsys_sw_irq_ctrl;

  localparam int DW = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [31:0]   readdata;
  logic [DW-1:0] in_port;
  logic          irq;

  typedef struct {
    string       name;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs [8];
  int          n_vec  = 0;
  int          n_miss = 0;
  logic [31:0] exp_q  [$];
  string       name_q [$];

  de10lite_qsys_sw_irq_ctrl #(
    .DW          (10),
    .CNT_W       (16),
    .DEB_DEFAULT (50000)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .in_port    (in_port),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle(input int n);
    repeat (n) tick();
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
    end
  endtask

  task automatic check_irq(input string nm, input logic exp);
    check(nm, {31'b0, irq}, {31'b0, exp});
  endtask

  task automatic drain();
    while (exp_q.size() > 0) check(name_q.pop_front(), readdata, exp_q.pop_front());
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd(input string nm, input logic [1:0] a, input logic [31:0] e);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    exp_q.push_back(e);
    name_q.push_back(nm);
    tick();
    chipselect = 1'b0;
    drain();
  endtask

  // Drive a level for n cycles while confirming irq stays low.
  task automatic hold(input logic [DW-1:0] v, input int n, input string nm);
    in_port = v;
    for (int k = 0; k < n; k++) begin
      tick();
      check_irq(nm, 1'b0);
    end
  endtask

  initial begin
    vecs[0] = '{"mask_all_ones",  2'd1, 32'hFFFF_FFFF, 32'h0000_03FF};
    vecs[1] = '{"mask_pattern",   2'd1, 32'h0000_0155, 32'h0000_0155};
    vecs[2] = '{"mask_zero",      2'd1, 32'h0000_0000, 32'h0000_0000};
    vecs[3] = '{"period_ones",    2'd3, 32'hFFFF_FFFF, 32'h0000_FFFF};
    vecs[4] = '{"period_trunc",   2'd3, 32'h0001_2345, 32'h0000_2345};
    vecs[5] = '{"deb_read_only",  2'd0, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[6] = '{"edgecap_w1c",    2'd2, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[7] = '{"period_three",   2'd3, 32'h0000_0003, 32'h0000_0003};

    reset      = 1'b1;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in_port    = '0;

    // Reset state
    settle(2);
    check("reset_readdata", readdata, 32'h0);
    check_irq("reset_irq", 1'b0);
    reset = 1'b0;
    rd("rst_period", 2'd3, 32'd50000);
    rd("rst_deb",    2'd0, 32'h0);
    rd("rst_mask",   2'd1, 32'h0);
    rd("rst_ecap",   2'd2, 32'h0);

    // Register write/readback table
    for (int v = 0; v < 8; v++) begin
      wr(vecs[v].addr, vecs[v].wdata);
      rd(vecs[v].name, vecs[v].addr, vecs[v].exp);
    end

    // Read in the same cycle as a write returns the old value
    wr(2'd1, 32'h0AA);
    wr(2'd1, 32'h155);
    check("rdw_old_value", readdata, 32'h0AA);
    rd("rdw_new_value", 2'd1, 32'h155);
    wr(2'd1, 32'h0);

    // period=3: deb[0] rises exactly 6 edges after in_port changes
    address = 2'd0;
    in_port = 10'h001;
    for (int k = 1; k <= 7; k++) begin
      tick();
      check($sformatf("deb_latency_e%0d", k), readdata, (k == 7) ? 32'h1 : 32'h0);
    end
    rd("deb0_set",   2'd0, 32'h001);
    rd("ecap0_set",  2'd2, 32'h001);
    in_port = '0;
    settle(8);
    wr(2'd2, 32'h3FF);
    rd("ecap0_clr",  2'd2, 32'h0);
    rd("deb0_fall",  2'd0, 32'h0);

    // period=3: 3-cycle pulse and a bounce are rejected, 4-cycle pulse is accepted
    wr(2'd1, 32'h3FF);
    hold(10'h010, 3, "short_pulse_irq");
    hold(10'h000, 8, "short_pulse_irq");
    hold(10'h010, 3, "bounce_irq");
    hold(10'h000, 1, "bounce_irq");
    hold(10'h010, 3, "bounce_irq");
    hold(10'h000, 8, "bounce_irq");
    rd("short_deb",  2'd0, 32'h0);
    rd("short_ecap", 2'd2, 32'h0);
    in_port = 10'h010;
    settle(4);
    in_port = '0;
    settle(10);
    rd("long_pulse_ecap", 2'd2, 32'h010);
    check_irq("long_pulse_irq", 1'b1);
    wr(2'd2, 32'h3FF);
    wr(2'd1, 32'h0);
    tick();
    check_irq("long_pulse_irq_clr", 1'b0);

    // period=0, irqmask=0x010: irq one cycle after edgecap[4] sets, clears after W1C
    wr(2'd3, 32'h0);
    wr(2'd1, 32'h010);
    in_port = 10'h010;
    for (int k = 1; k <= 4; k++) begin
      tick();
      check_irq($sformatf("irq_rise_e%0d", k), k == 4);
    end
    wr(2'd2, 32'h010);
    check_irq("irq_at_w1c_edge", 1'b1);
    tick();
    check_irq("irq_after_w1c", 1'b0);
    rd("ecap4_clr", 2'd2, 32'h0);
    in_port = '0;
    settle(5);
    wr(2'd1, 32'h0);
    wr(2'd2, 32'h3FF);
    tick();
    check_irq("irq_quiet", 1'b0);

    // W1C of all bits on the same edge deb[9] changes: the set wins
    in_port = 10'h200;
    settle(2);
    wr(2'd2, 32'h3FF);
    rd("set_wins_ecap", 2'd2, 32'h200);
    rd("set_wins_deb",  2'd0, 32'h200);
    in_port = '0;
    settle(5);
    wr(2'd2, 32'h3FF);

    // Lowering period mid-count keeps the counter and fires on the next mismatch
    wr(2'd3, 32'd10);
    in_port = 10'h002;
    settle(6);
    wr(2'd3, 32'd2);
    address = 2'd0;
    tick();
    check("period_change_e8", readdata, 32'h0);
    tick();
    check("period_change_e9", readdata, 32'h002);
    wr(2'd1, 32'h3FF);
    tick();
    check_irq("irq_pending_bit1", 1'b1);

    // Reset mid-count discards progress and re-debounces with the default period
    wr(2'd3, 32'd100);
    in_port = 10'h3FF;
    settle(50);
    check_irq("irq_before_reset", 1'b1);
    reset = 1'b1;
    tick();
    check("reset_mid_readdata", readdata, 32'h0);
    check_irq("reset_mid_irq", 1'b0);
    tick();
    reset   = 1'b0;
    address = 2'd3;
    tick();
    check("post_rst_period", readdata, 32'd50000);
    address = 2'd1;
    tick();
    check("post_rst_mask", readdata, 32'h0);
    address = 2'd0;
    for (int k = 3; k <= 50003; k++) tick();
    check("redeb_e50003", readdata, 32'h0);
    tick();
    check("redeb_e50004", readdata, 32'h3FF);
    rd("redeb_ecap", 2'd2, 32'h3FF);
    check_irq("redeb_irq_masked", 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
